// File: rtl/wb_queue.sv
// Write-back queue between the ALU/load return paths and a single register-file
// write port. Pending results sit in a small circular FIFO, drain in acceptance
// order whenever the port is free, and can be forwarded to consumers while they
// wait.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    input  logic [4:0]                alu_addr,
    input  logic [31:0]               alu_data,
    input  logic                      ld_valid,
    input  logic [4:0]                ld_addr,
    input  logic [31:0]               ld_data,
    output logic                      in_ready,
    input  logic                      rf_busy,
    output logic                      wr,
    output logic [4:0]                addr3,
    output logic [31:0]               data3,
    input  logic [4:0]                fwd_addr,
    output logic                      fwd_hit,
    output logic [31:0]               fwd_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          ovf_q;

    logic [CW-1:0] free_slots;
    logic          alu_req;
    logic          ld_req;
    logic          alu_acc;
    logic          ld_acc;
    logic [PW-1:0] ld_slot;
    logic [CW-1:0] n_acc;
    logic          fwd_hit_c;
    logic [31:0]   fwd_data_c;

    // Admission: two free slots are required so a dual accept can never overflow.
    // Register 0 is hard-wired, so writes to it are silently discarded.
    always_comb begin
        free_slots = CW'(DEPTH) - cnt;
        in_ready   = free_slots >= CW'(2);
        alu_req    = alu_valid && (alu_addr != 5'd0);
        ld_req     = ld_valid && (ld_addr != 5'd0);
        alu_acc    = alu_req && in_ready;
        ld_acc     = ld_req && in_ready;
        ld_slot    = tail + PW'(alu_acc);
        n_acc      = CW'(alu_acc) + CW'(ld_acc);
    end

    // Register-file port: the head entry drives the port straight from storage,
    // so a freshly accepted entry shows up one cycle after its acceptance edge.
    always_comb begin
        wr    = (cnt != '0) && !rf_busy;
        addr3 = '0;
        data3 = '0;
        if (cnt != '0) begin
            addr3 = mem_addr[head];
            data3 = mem_data[head];
        end
    end

    // Forwarding scans oldest to youngest so the last match found is the youngest.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < cnt) && (fwd_addr != 5'd0) &&
                (mem_addr[head + PW'(i)] == fwd_addr)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = mem_data[head + PW'(i)];
            end
        end
        fwd_hit  = fwd_hit_c;
        fwd_data = fwd_data_c;
    end

    // Entry storage; the ALU result takes the older slot on a dual accept.
    always_ff @(posedge clk) begin
        if (alu_acc) begin
            mem_addr[tail] <= alu_addr;
            mem_data[tail] <= alu_data;
        end
        if (ld_acc) begin
            mem_addr[ld_slot] <= ld_addr;
            mem_data[ld_slot] <= ld_data;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            tail <= tail + PW'(n_acc);
            head <= head + PW'(wr);
            cnt  <= cnt + n_acc - CW'(wr);
            if ((alu_req || ld_req) && !in_ready) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign count = cnt;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of pending write-backs.
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [4:0]    alu_addr = '0;
    logic [31:0]   alu_data = '0;
    logic          ld_valid = 1'b0;
    logic [4:0]    ld_addr = '0;
    logic [31:0]   ld_data = '0;
    logic          in_ready;
    logic          rf_busy = 1'b0;
    logic          wr;
    logic [4:0]    addr3;
    logic [31:0]   data3;
    logic [4:0]    fwd_addr = '0;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [CW-1:0] count;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    bit   m_ovf = 1'b0;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .in_ready(in_ready), .rf_busy(rf_busy),
        .wr(wr), .addr3(addr3), .data3(data3),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs derived from the list of pending entries.
    task automatic check_all();
        int          sz;
        logic        e_wr;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic        e_hit;
        logic [31:0] e_fd;
        sz    = q.size();
        e_wr  = (sz != 0) && !rf_busy && rst_n;
        e_a   = (sz != 0) ? q[0].a : 5'd0;
        e_d   = (sz != 0) ? q[0].d : 32'd0;
        e_hit = 1'b0;
        e_fd  = 32'd0;
        if (fwd_addr != 5'd0) begin
            for (int i = sz - 1; i >= 0; i--) begin
                if (q[i].a == fwd_addr) begin
                    e_hit = 1'b1;
                    e_fd  = q[i].d;
                    break;
                end
            end
        end
        check("count", 32'(count), 32'(sz));
        check("in_ready", 32'(in_ready), 32'((DEPTH - sz) >= 2));
        check("wr", 32'(wr), 32'(e_wr));
        check("addr3", 32'(addr3), 32'(e_a));
        check("data3", data3, e_d);
        check("fwd_hit", 32'(fwd_hit), 32'(e_hit));
        check("fwd_data", fwd_data, e_fd);
        check("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                         input logic busy, input logic [4:0] fa);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid  = lv; ld_addr  = la; ld_data  = ldd;
        rf_busy   = busy; fwd_addr = fa;
    endtask

    task automatic idle(input logic busy, input logic [4:0] fa);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, busy, fa);
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    // Advance one clock edge and apply the queue rules to the model.
    task automatic edge_update();
        int sz;
        bit ir;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            sz = q.size();
            ir = (DEPTH - sz) >= 2;
            if (sz != 0 && !rf_busy) void'(q.pop_front());
            if (alu_valid && alu_addr != 5'd0) begin
                if (ir) q.push_back('{alu_addr, alu_data});
                else    m_ovf = 1'b1;
            end
            if (ld_valid && ld_addr != 5'd0) begin
                if (ir) q.push_back('{ld_addr, ld_data});
                else    m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic step();
        settle();
        edge_update();
    endtask

    initial begin
        // Reset state
        idle(1'b0, 5'd0);
        #3;
        check_all();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        edge_update();
        #2 rst_n = 1'b1;
        edge_update();

        // Single write
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        step();
        idle(1'b0, 5'd5);
        settle();
        check("single_wr", 32'(wr), 32'd1);
        check("single_addr3", 32'(addr3), 32'd5);
        check("single_data3", data3, 32'h1234);
        edge_update();
        settle();
        check("single_count0", 32'(count), 32'd0);

        // Dual accept with forwarding before the first write
        drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 1'b0, 5'd3);
        step();
        idle(1'b1, 5'd3);
        settle();
        check("dual_fwd_hit", 32'(fwd_hit), 32'd1);
        check("dual_fwd_data", fwd_data, 32'hB);
        edge_update();
        idle(1'b0, 5'd3);
        settle();
        check("dual_first", data3, 32'hA);
        edge_update();
        settle();
        check("dual_second", data3, 32'hB);
        edge_update();
        step();

        // Zero register is discarded
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0);
        step();
        idle(1'b0, 5'd0);
        settle();
        check("zero_count", 32'(count), 32'd0);
        check("zero_wr", 32'(wr), 32'd0);
        check("zero_ovf", 32'(ovf), 32'd0);

        // Backpressure until full, one dropped request, then drain across the wrap
        for (int i = 0; i < DEPTH && (DEPTH - q.size()) >= 2; i++) begin
            drive(1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b1, 5'(20 + i), 32'h200 + 32'(i), 1'b1, 5'd0);
            step();
        end
        drive(1'b1, 5'd7, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        settle();
        check("bp_in_ready", 32'(in_ready), 32'd0);
        edge_update();
        idle(1'b1, 5'd7);
        settle();
        check("bp_ovf", 32'(ovf), 32'd1);
        check("bp_dropped_fwd", 32'(fwd_hit), 32'd0);
        for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) begin
            idle(1'b0, 5'd0);
            step();
        end
        settle();
        check("bp_drained", 32'(count), 32'd0);

        // Concurrent enqueue of two with a dequeue at count=2
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 5'd0);
        step();
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
        settle();
        check("conc_pre_count", 32'(count), 32'd2);
        edge_update();
        idle(1'b1, 5'd6);
        settle();
        check("conc_count3", 32'(count), 32'd3);

        // Asynchronous reset mid-cycle with entries pending
        #2 rst_n = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check_all();
        idle(1'b0, 5'd6);
        edge_update();
        settle();
        check("rst_hold_wr", 32'(wr), 32'd0);
        #2 rst_n = 1'b1;
        edge_update();
        settle();
        check("rst_no_stale", 32'(wr), 32'd0);
        edge_update();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)));
            step();
        end
        idle(1'b0, 5'd0);
        for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) step();
        settle();
        check("final_empty", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of pending write-back entries (power of two, >= 2).
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 alu_valid  input  1  ALU write-back request.
REQ-006 alu_addr  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 ld_valid  input  1  load write-back request.
REQ-009 ld_addr  input  5  load destination register.
REQ-010 ld_data  input  32  load data.
REQ-011 in_ready  output  1  high when at least 2 entries are free.
REQ-012 rf_busy  input  1  register-file write port unavailable this cycle.
REQ-013 wr  output  1  register-file write enable.
REQ-014 addr3  output  5  register-file write address.
REQ-015 data3  output  32  register-file write data.
REQ-016 fwd_addr  input  5  forwarding lookup address.
REQ-017 fwd_hit  output  1  a pending entry targets fwd_addr.
REQ-018 fwd_data  output  32  data of the youngest matching pending entry.
REQ-019 count  output  $clog2(DEPTH)+1  number of pending entries.
REQ-020 ovf  output  1  sticky overflow flag.

Function
REQ-021 Storage SHALL be a circular FIFO of DEPTH entries {addr[4:0], data[31:0]} with head/tail pointers wrapping modulo DEPTH.
REQ-022 in_ready SHALL be combinational: (DEPTH - count) >= 2.
REQ-023 A request with valid=1 and in_ready=1 SHALL be enqueued at the clock edge; a request with addr=0 SHALL be discarded (not enqueued, no ovf).
REQ-024 When both requests are accepted in one cycle, the ALU entry SHALL occupy the older slot and the load entry the next slot.
REQ-025 A valid request with addr!=0 while in_ready=0 SHALL be dropped and SHALL set ovf=1, which stays set until reset.
REQ-026 wr SHALL be combinational: (count != 0) && !rf_busy; addr3/data3 SHALL equal the head entry whenever count != 0, and 0 when empty.
REQ-027 The head entry SHALL be dequeued at each edge where wr=1.
REQ-028 Latency: an entry accepted at edge N into an empty queue SHALL appear on wr/addr3/data3 in the cycle after edge N; no same-cycle bypass from request inputs to the write port.
REQ-029 Simultaneous enqueue (up to 2) and dequeue in one cycle SHALL be supported; count(next) = count + accepted - dequeued.
REQ-030 rf_busy=1 SHALL hold head, count and outputs unchanged except for enqueues.
REQ-031 fwd_hit/fwd_data SHALL be combinational over stored entries only (including the head currently driven on wr); the youngest match wins; fwd_addr=0 SHALL give fwd_hit=0.
REQ-032 fwd_data SHALL be 0 when fwd_hit=0.
REQ-033 Entries SHALL be written to the register file strictly in acceptance order; no coalescing of same-address entries.

Reset
REQ-034 rst_n=0 SHALL immediately clear head, tail, count and ovf; wr=0, addr3=0, data3=0, fwd_hit=0, fwd_data=0, in_ready=1.
REQ-035 Pending entries at reset assertion SHALL be lost; no write issues while rst_n=0.
REQ-036 Entry storage contents need no reset; they SHALL be unobservable while count=0.

Verification
REQ-037 Single write: alu_valid, addr=5, data=0x1234 into empty queue -> next cycle wr=1, addr3=5, data3=0x1234; count returns to 0 after the following edge.
REQ-038 Dual accept: alu {3,0xA}, ld {3,0xB} same cycle -> writes issue in order 0xA then 0xB; fwd_addr=3 before the first write gives fwd_hit=1, fwd_data=0xB.
REQ-039 Backpressure/wrap: rf_busy=1, enqueue until in_ready=0 (count=DEPTH-1 or DEPTH), one more valid request -> dropped, ovf=1; release rf_busy -> all entries drain in order across pointer wrap.
REQ-040 Zero register: ld_valid with addr=0, data=0xFFFF -> count unchanged, wr stays 0, ovf stays 0.
REQ-041 Reset mid-operation: 3 entries pending, rf_busy=1, assert rst_n=0 asynchronously mid-cycle -> count=0, wr=0, ovf=0 immediately; after release no stale write issues.
REQ-042 Concurrent: count=2, wr=1, both requests accepted in same cycle -> count=3 after edge.
